// File: rtl/mmio_timer_if.sv
// rtl/mmio_timer_if.sv - request/acknowledge register bus between an initiator and the timer
interface mmio_timer_if;
    logic        Read;
    logic        Write;
    logic [1:0]  Address;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        Ack;

    modport master (
        output Read, Write, Address, DataIn,
        input  DataOut, Ack
    );

    modport slave (
        input  Read, Write, Address, DataIn,
        output DataOut, Ack
    );
endinterface

// File: rtl/mmio_timer.sv
// rtl/mmio_timer.sv - register-mapped down-counting timer with prescaler, auto-reload and sticky expiry interrupt
module mmio_timer #(
    parameter int COUNT_WIDTH = 32
) (
    input  logic        clock,
    input  logic        reset,
    mmio_timer_if.slave bus,
    output logic        Interrupt
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ACK  = 1'b1;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_LOAD   = 2'd1;
    localparam logic [1:0] A_COUNT  = 2'd2;
    localparam logic [1:0] A_STATUS = 2'd3;

    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

    logic [0:0]             state_q, state_d;
    logic                   en_q, en_d;
    logic                   auto_q, auto_d;
    logic                   ie_q, ie_d;
    logic [7:0]             pre_q, pre_d;
    logic [7:0]             presc_q, presc_d;
    logic [COUNT_WIDTH-1:0] load_q, load_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   expired_q, expired_d;
    logic [31:0]            dout_q, dout_d;

    logic        req, access, wr, rd;
    logic        wr_ctrl, wr_load, wr_count, wr_status;
    logic        tick, expire;
    logic [31:0] load_ext, count_ext, rdata;

    always_comb begin
        req       = bus.Read | bus.Write;
        access    = (state_q == ST_IDLE) && req;
        wr        = access && bus.Write;
        rd        = access && !bus.Write;
        wr_ctrl   = wr && (bus.Address == A_CTRL);
        wr_load   = wr && (bus.Address == A_LOAD);
        wr_count  = wr && (bus.Address == A_COUNT);
        wr_status = wr && (bus.Address == A_STATUS);
        // A software COUNT write on a tick edge wins: the tick is dropped entirely.
        tick      = en_q && (presc_q == pre_q) && !wr_count;
        expire    = tick && (count_q == '0);
    end

    always_comb begin
        load_ext                     = '0;
        load_ext[COUNT_WIDTH-1:0]    = load_q;
        count_ext                    = '0;
        count_ext[COUNT_WIDTH-1:0]   = count_q;
        case (bus.Address)
            A_CTRL:  rdata = {16'h0, pre_q, 5'h0, ie_q, auto_q, en_q};
            A_LOAD:  rdata = load_ext;
            A_COUNT: rdata = count_ext;
            default: rdata = {31'h0, expired_q};
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req)  state_d = ST_ACK;
            default: if (!req) state_d = ST_IDLE;
        endcase

        en_d   = en_q;
        auto_d = auto_q;
        ie_d   = ie_q;
        pre_d  = pre_q;
        if (wr_ctrl) begin
            en_d   = bus.DataIn[0];
            auto_d = bus.DataIn[1];
            ie_d   = bus.DataIn[2];
            pre_d  = bus.DataIn[15:8];
        end else if (expire && !auto_q) begin
            en_d = 1'b0;
        end

        load_d = wr_load ? bus.DataIn[COUNT_WIDTH-1:0] : load_q;

        count_d = count_q;
        if (wr_count) begin
            count_d = bus.DataIn[COUNT_WIDTH-1:0];
        end else if (tick) begin
            if (count_q != '0) count_d = count_q - CNT_ONE;
            else if (auto_q)   count_d = load_q;
        end

        // Set beats clear so an expiry is never lost to a racing acknowledge.
        expired_d = expired_q;
        if (wr_status && bus.DataIn[0]) expired_d = 1'b0;
        if (expire)                     expired_d = 1'b1;

        if (!en_q || wr_ctrl || wr_count || tick) presc_d = '0;
        else                                      presc_d = presc_q + 8'd1;

        dout_d = rd ? rdata : dout_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            en_q      <= 1'b0;
            auto_q    <= 1'b0;
            ie_q      <= 1'b0;
            pre_q     <= '0;
            presc_q   <= '0;
            load_q    <= '0;
            count_q   <= '0;
            expired_q <= 1'b0;
            dout_q    <= '0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            auto_q    <= auto_d;
            ie_q      <= ie_d;
            pre_q     <= pre_d;
            presc_q   <= presc_d;
            load_q    <= load_d;
            count_q   <= count_d;
            expired_q <= expired_d;
            dout_q    <= dout_d;
        end
    end

    assign bus.Ack     = (state_q == ST_ACK);
    assign bus.DataOut = dout_q;
    assign Interrupt   = expired_q & ie_q;
endmodule

// File: doc/mmio_timer.md
MMIO_TIMER -- requirements
Module: mmio_timer

Interface
REQ-001 Parameter: COUNT_WIDTH, default 32, width of LOAD and COUNT registers (legal range 8..32).
REQ-002 Port: clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on the rising clock edge.
REQ-004 Port: Read  input  1  bus read request from initiator; held until Ack seen.
REQ-005 Port: Write  input  1  bus write request from initiator; held until Ack seen.
REQ-006 Port: Address  input  2  word-register select: 0=CONTROL, 1=LOAD, 2=COUNT, 3=STATUS.
REQ-007 Port: DataIn  input  32  write data.
REQ-008 Port: DataOut  output  32  read data; valid while Ack high after a read.
REQ-009 Port: Ack  output  1  responder handshake acknowledge.
REQ-010 Port: Interrupt  output  1  level interrupt = STATUS.EXPIRED & CONTROL.IE.

Function
REQ-011 CONTROL SHALL hold bit0 EN, bit1 AUTO (auto-reload), bit2 IE, bits[15:8] PRESCALE; other bits SHALL read 0.
REQ-012 STATUS SHALL hold bit0 EXPIRED (sticky); writing 1 to bit0 SHALL clear it, writing 0 SHALL have no effect.
REQ-013 LOAD and COUNT SHALL be COUNT_WIDTH bits, zero-extended to 32 on read; writes SHALL use DataIn[COUNT_WIDTH-1:0].
REQ-014 Handshake FSM SHALL have states IDLE and ACK; reset state IDLE.
REQ-015 IDLE: on Read|Write high, the access SHALL be performed at that edge, Ack SHALL be 1 the next cycle, go to ACK.
REQ-016 ACK: Ack SHALL stay 1 while Read|Write high; when both low, Ack SHALL be 0 the next cycle, go to IDLE; no new access SHALL be performed in ACK.
REQ-017 Read and Write both high in IDLE: write SHALL be performed, DataOut SHALL be unchanged.
REQ-018 Read: DataOut SHALL capture the register value present at the IDLE sampling edge and hold it until the next read.
REQ-019 Prescaler: an 8-bit counter SHALL generate one tick every PRESCALE+1 cycles while EN=1; PRESCALE=0 SHALL tick every cycle.
REQ-020 Prescaler SHALL clear when EN is 0, on any CONTROL write, and on any COUNT write.
REQ-021 On tick with COUNT!=0: COUNT SHALL decrement by 1.
REQ-022 On tick with COUNT==0: EXPIRED SHALL set; if AUTO=1, COUNT SHALL load LOAD; if AUTO=0, COUNT SHALL stay 0 and EN SHALL clear (one-shot).
REQ-023 Software COUNT write coincident with a tick SHALL win; the tick SHALL be discarded.
REQ-024 Software CONTROL write coincident with one-shot EN clear SHALL win.
REQ-025 Expiry set coincident with a STATUS clear write SHALL leave EXPIRED=1.
REQ-026 AUTO=1 with LOAD=0 SHALL expire on every tick.
REQ-027 Interrupt SHALL be combinational from registered EXPIRED and IE, with no further delay.

Reset
REQ-028 On reset: CONTROL=0, LOAD=0, COUNT=0, STATUS=0, prescaler=0, FSM=IDLE, Ack=0, DataOut=0, Interrupt=0.
REQ-029 Reset asserted mid-handshake SHALL return FSM to IDLE with Ack=0 the next cycle; a request still held after reset release SHALL be treated as new.
REQ-030 Reset coincident with a Write SHALL discard the write.

Verification
REQ-031 Write LOAD=5, COUNT=5, CONTROL=0x7 (EN,AUTO,IE, PRESCALE=0) -> EXPIRED and Interrupt set 6 cycles after CONTROL write edge; COUNT reloads 5; repeats every 6 cycles.
REQ-032 One-shot: COUNT=3, CONTROL=0x05 with PRESCALE=2 (0x0205) -> expiry after 12 cycles; CONTROL reads 0x0204 afterward; COUNT reads 0.
REQ-033 Handshake: Read held 4 cycles at Address=1 -> Ack high cycles 2..5, low one cycle after Read drops; exactly one access; DataOut=LOAD.
REQ-034 Write STATUS=1 on the same edge expiry occurs -> EXPIRED reads 1; subsequent STATUS=1 write -> 0, Interrupt low.
REQ-035 Simultaneous Read+Write to LOAD with DataIn=0xA5 -> LOAD=0xA5, DataOut holds prior value.
REQ-036 Reset asserted while in ACK with EN=1 -> all registers 0, Ack=0 next cycle, no further ticks.
